// File: rtl/linkinit_responder.sv
//==============================================================================
// Module   : linkinit_responder (with SB_codex_pkg)
// Brief    : LINKINIT responder - takes the partner's active request from the
//            sideband RX path and answers with the active response.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package SB_codex_pkg;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  src_id;
        logic [2:0]  dst_id;
        logic [7:0]  msg_code;
        logic [7:0]  msg_subcode;
        logic [15:0] msg_info;
        logic [63:0] data;
    } SB_msg_t;

    localparam logic [7:0] LINKINIT_ACTIVE_REQ = 8'h01;
    localparam logic [7:0] LINKINIT_ACTIVE_RSP = 8'h02;

endpackage

module linkinit_responder
    import SB_codex_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1000,
    parameter int DROP_CNT_W  = 4
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic                  enable_i,
    output SB_msg_t               TX_msg_o,
    output logic                  TX_msg_valid_o,
    input  logic                  TX_msg_valid_ack_i,
    input  SB_msg_t               RX_msg_i,
    input  logic                  RX_msg_valid_i,
    output logic                  RX_msg_req_o,
    output logic                  LINKINIT_RSP_done_o,
    output logic                  error_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o,
    output logic                  reset_state_timeout_counter_o
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_WAIT_REQ = 3'd1;
    localparam logic [2:0] c_SEND_RSP = 3'd2;
    localparam logic [2:0] c_DONE     = 3'd3;
    localparam logic [2:0] c_ERR      = 3'd4;

    localparam logic [15:0] c_ACK_LAST = 16'(ACK_TIMEOUT - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [15:0]           r_ack_cnt;
    logic [15:0]           w_ack_cnt_next;
    logic [DROP_CNT_W-1:0] w_drop_next;
    logic                  w_rx_xfer;
    logic                  w_is_req;
    logic                  w_pulse;
    SB_msg_t               w_tx_msg;
    logic                  w_unused_rx;

    // Only the message code of incoming traffic matters here.
    assign w_unused_rx = ^RX_msg_i;

    assign w_rx_xfer = RX_msg_valid_i && RX_msg_req_o;
    assign w_is_req  = (RX_msg_i.msg_code == LINKINIT_ACTIVE_REQ);

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            r_state   <= c_IDLE;
            r_ack_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_ack_cnt <= w_ack_cnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!enable_i) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:     w_next_state = c_WAIT_REQ;
                c_WAIT_REQ: if (w_rx_xfer && w_is_req) w_next_state = c_SEND_RSP;
                c_SEND_RSP: begin
                    // An ack in the final waiting cycle still completes.
                    if (TX_msg_valid_ack_i)
                        w_next_state = c_DONE;
                    else if (r_ack_cnt >= c_ACK_LAST)
                        w_next_state = c_ERR;
                end
                c_DONE:     w_next_state = c_DONE;
                c_ERR:      w_next_state = c_ERR;
                default:    w_next_state = c_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and then registered.
    always_comb begin
        w_tx_msg = '0;
        if (w_next_state == c_SEND_RSP)
            w_tx_msg.msg_code = LINKINIT_ACTIVE_RSP;

        w_pulse = enable_i &&
                  (((r_state == c_WAIT_REQ) && w_rx_xfer && w_is_req) ||
                   ((r_state == c_SEND_RSP) && TX_msg_valid_ack_i));

        w_drop_next = drop_cnt_o;
        if (!enable_i)
            w_drop_next = '0;
        else if ((r_state == c_WAIT_REQ) && w_rx_xfer && !w_is_req && !(&drop_cnt_o))
            w_drop_next = drop_cnt_o + 1'b1;

        w_ack_cnt_next = '0;
        if ((r_state == c_SEND_RSP) && (w_next_state == c_SEND_RSP))
            w_ack_cnt_next = r_ack_cnt + 16'd1;
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            TX_msg_o                      <= '0;
            TX_msg_valid_o                <= 1'b0;
            RX_msg_req_o                  <= 1'b0;
            LINKINIT_RSP_done_o           <= 1'b0;
            error_o                       <= 1'b0;
            drop_cnt_o                    <= '0;
            reset_state_timeout_counter_o <= 1'b0;
        end else begin
            TX_msg_o                      <= w_tx_msg;
            TX_msg_valid_o                <= (w_next_state == c_SEND_RSP);
            RX_msg_req_o                  <= (w_next_state == c_WAIT_REQ);
            LINKINIT_RSP_done_o           <= (w_next_state == c_DONE);
            error_o                       <= (w_next_state == c_ERR);
            drop_cnt_o                    <= w_drop_next;
            reset_state_timeout_counter_o <= w_pulse;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_linkinit_responder.sv
//==============================================================================
// Module   : tb_linkinit_responder
// Brief    : Directed self-checking bench for linkinit_responder.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_linkinit_responder;
    import SB_codex_pkg::*;

    logic    clk;
    logic    rst_n;

    logic    en, ack, rx_v;
    SB_msg_t rx_msg, tx_msg;
    logic    tx_v, rx_req, done, err, rstpulse;
    logic [3:0] drop;

    logic    en1, ack1, rx_v1;
    SB_msg_t rx_msg1, tx_msg1;
    logic    tx_v1, rx_req1, done1, err1, rstpulse1;
    logic [1:0] drop1;

    SB_msg_t req_msg, bad_msg, exp_rsp;
    int      n_pass, n_total, pulse_cnt;

    linkinit_responder #(.ACK_TIMEOUT(1000), .DROP_CNT_W(4)) u_dut (
        .clk_100MHz                    (clk),
        .reset                         (rst_n),
        .enable_i                      (en),
        .TX_msg_o                      (tx_msg),
        .TX_msg_valid_o                (tx_v),
        .TX_msg_valid_ack_i            (ack),
        .RX_msg_i                      (rx_msg),
        .RX_msg_valid_i                (rx_v),
        .RX_msg_req_o                  (rx_req),
        .LINKINIT_RSP_done_o           (done),
        .error_o                       (err),
        .drop_cnt_o                    (drop),
        .reset_state_timeout_counter_o (rstpulse)
    );

    linkinit_responder #(.ACK_TIMEOUT(8), .DROP_CNT_W(2)) u_dut_small (
        .clk_100MHz                    (clk),
        .reset                         (rst_n),
        .enable_i                      (en1),
        .TX_msg_o                      (tx_msg1),
        .TX_msg_valid_o                (tx_v1),
        .TX_msg_valid_ack_i            (ack1),
        .RX_msg_i                      (rx_msg1),
        .RX_msg_valid_i                (rx_v1),
        .RX_msg_req_o                  (rx_req1),
        .LINKINIT_RSP_done_o           (done1),
        .error_o                       (err1),
        .drop_cnt_o                    (drop1),
        .reset_state_timeout_counter_o (rstpulse1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rstpulse) pulse_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] all_outs();
        return {10'd0, tx_v, rx_req, done, err, drop, rstpulse, tx_msg};
    endfunction

    initial begin
        n_pass = 0; n_total = 0; pulse_cnt = 0;
        req_msg = '0; req_msg.msg_code = LINKINIT_ACTIVE_REQ; req_msg.data = 64'hDEAD_BEEF;
        bad_msg = '0; bad_msg.msg_code = 8'h55;
        exp_rsp = '0; exp_rsp.msg_code = LINKINIT_ACTIVE_RSP;
        rst_n = 1'b0; en = 0; ack = 0; rx_v = 0; rx_msg = '0;
        en1 = 0; ack1 = 0; rx_v1 = 0; rx_msg1 = '0;
        tick(); tick();
        check("reset_outputs", all_outs(), '0);
        rst_n = 1'b1;
        pulse_cnt = 0;

        // Basic exchange
        en = 1;
        tick();
        check("wait_req_req", rx_req, 1);
        check("wait_req_txv", tx_v, 0);
        rx_msg = req_msg; rx_v = 1;
        tick();
        rx_v = 0;
        check("rsp_valid", tx_v, 1);
        check("rsp_req_low", rx_req, 0);
        check("rsp_msg", tx_msg, exp_rsp);
        check("req_pulse", rstpulse, 1);
        tick();
        check("pulse_single", rstpulse, 0);
        check("rsp_still_valid", tx_v, 1);
        ack = 1;
        tick();
        ack = 0;
        check("done_after_ack", done, 1);
        check("txv_after_ack", tx_v, 0);
        check("ack_pulse", rstpulse, 1);
        tick(); tick();
        check("pulse_count", pulse_cnt, 2);
        check("basic_no_err", err, 0);
        check("done_held", done, 1);

        // Unexpected traffic
        en = 0;
        tick();
        check("disable_clears", all_outs(), '0);
        en = 1;
        tick();
        rx_msg = bad_msg; rx_v = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drop_count", drop, i + 1);
        end
        rx_msg = req_msg;
        tick();
        rx_v = 0;
        check("rsp_after_drops", tx_v, 1);
        check("drop_final", drop, 3);
        ack = 1;
        tick();
        ack = 0;
        check("done_after_drops", done, 1);

        // Saturation and timeout on the small instance
        en1 = 1;
        tick();
        rx_msg1 = bad_msg; rx_v1 = 1;
        repeat (5) tick();
        check("drop_saturated", drop1, 3);
        rx_msg1 = req_msg;
        tick();
        rx_v1 = 0;
        check("to_rsp_valid", tx_v1, 1);
        repeat (7) tick();
        check("to_cycle8_valid", tx_v1, 1);
        check("to_cycle8_noerr", err1, 0);
        tick();
        check("to_err", err1, 1);
        check("to_txv_low", tx_v1, 0);
        check("to_no_done", done1, 0);
        check("to_drop_kept", drop1, 3);

        // Abort mid-send together with an ack
        en = 0; tick(); en = 1; tick();
        rx_msg = req_msg; rx_v = 1;
        tick();
        rx_v = 0;
        check("abort_pre_valid", tx_v, 1);
        en = 0; ack = 1;
        tick();
        ack = 0;
        check("abort_idle", all_outs(), '0);
        en = 1;
        tick();
        check("reenable_req", rx_req, 1);
        rx_v = 1;
        tick();
        rx_v = 0;
        check("reenable_valid", tx_v, 1);
        ack = 1;
        tick();
        ack = 0;
        check("reenable_done", done, 1);

        // Asynchronous reset mid-send
        en = 0; tick(); en = 1; tick();
        rx_v = 1;
        tick();
        rx_v = 0;
        check("areset_pre_valid", tx_v, 1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_immediate", all_outs(), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("areset_idle", all_outs(), '0);
        tick();
        check("areset_resume", rx_req, 1);

        // Back-pressure hold
        rx_v = 1;
        tick();
        rx_v = 0;
        for (int i = 0; i < 20; i++) begin
            check("hold_valid", tx_v, 1);
            check("hold_msg", tx_msg, exp_rsp);
            if (i < 19) tick();
        end
        ack = 1;
        tick();
        ack = 0;
        check("hold_done", done, 1);
        check("hold_no_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/linkinit_responder.md
# linkinit_responder

Responder half of the LINKINIT sideband exchange in the logical-PHY LTSM. While LINKINIT is active, it accepts the partner's LINKINIT active-request message from the sideband RX path. It then answers with the matching response on the sideband TX path and reports completion to the LTSM top. It runs on the 100 MHz sideband clock and uses the same valid/req and valid/ack message handshakes as the other LTSM state blocks.

## Interface
Parameters:
- ACK_TIMEOUT, default 1000: number of clk_100MHz cycles to wait for TX_msg_valid_ack_i before flagging an error (range 1..65535).
- DROP_CNT_W, default 4: width of the saturating count of discarded messages.

Ports:
- clk_100MHz  in  1  sideband clock; the only clock in this block.
- reset  in  1  asynchronous, active-low reset.
- enable_i  in  1  LTSM is in LINKINIT; low means abort and idle.
- TX_msg_o  out  SB_msg_t  response message, held stable while TX_msg_valid_o is high.
- TX_msg_valid_o  out  1  response pending.
- TX_msg_valid_ack_i  in  1  TX path has taken the message.
- RX_msg_i  in  SB_msg_t  incoming message.
- RX_msg_valid_i  in  1  RX_msg_i is valid.
- RX_msg_req_o  out  1  ready to consume an RX message.
- LINKINIT_RSP_done_o  out  1  response delivered; held until enable_i falls.
- error_o  out  1  ACK timeout occurred; sticky until enable_i falls.
- drop_cnt_o  out  DROP_CNT_W  count of discarded (non-request) messages, saturating.
- reset_state_timeout_counter_o  out  1  single-cycle pulse telling the LTSM to restart its state timeout.

## Operation
- States: IDLE, WAIT_REQ, SEND_RSP, DONE, ERR.
- IDLE
  - All outputs are 0; TX_msg_o is all-zero.
  - If enable_i=1, go to WAIT_REQ.
- WAIT_REQ
  - RX_msg_req_o=1.
  - An RX transfer is the cycle where RX_msg_valid_i and RX_msg_req_o are both 1.
  - If RX_msg_i.msg_code is LINKINIT_ACTIVE_REQ (from SB_codex_pkg): pulse reset_state_timeout_counter_o, go to SEND_RSP.
  - Any other code: discard it, increment drop_cnt_o (saturates at all-ones), stay in WAIT_REQ.
- SEND_RSP
  - RX_msg_req_o=0.
  - TX_msg_valid_o=1; TX_msg_o is all-zero except msg_code=LINKINIT_ACTIVE_RSP.
  - A 16-bit counter counts cycles spent waiting.
  - TX_msg_valid_ack_i=1: pulse reset_state_timeout_counter_o, go to DONE.
  - Counter reaches ACK_TIMEOUT with no ack: go to ERR.
- DONE: LINKINIT_RSP_done_o=1; RX_msg_req_o=0. Late duplicate requests stay in the RX path and are not consumed.
- ERR: error_o=1; TX_msg_valid_o=0.
- enable_i=0 in any state:
  - Next state is IDLE.
  - done, error, drop_cnt_o and the ack counter clear.
  - Any pending TX_msg_valid_o is withdrawn on the next edge.

## Timing
- Reset (reset=0): state is IDLE and every output is 0, asynchronously.
- All outputs are registered; there is no combinational path from input to output.
- Request to response:
  - Transfer at edge N: TX_msg_valid_o=1 from edge N+1.
  - Ack sampled at edge M: TX_msg_valid_o=0 and LINKINIT_RSP_done_o=1 from edge M+1.
  - Minimum total is 2 cycles from request transfer to done.
- Ack in the first SEND_RSP cycle is legal.
- Ack and timeout in the same cycle: the ack wins (DONE).
- enable_i rising: WAIT_REQ and RX_msg_req_o=1 one cycle after the edge where enable_i is sampled high.
- enable_i falling and ack in the same cycle: abort wins (IDLE); done is never raised.
- reset_state_timeout_counter_o is high for exactly 1 cycle per event.
- drop_cnt_o updates at the edge following the transfer.

## Test plan
- Basic exchange: enable_i=1; request transfer at cycle 3; ack 2 cycles after TX_msg_valid_o rises.
  - Required: TX_msg_o.msg_code=LINKINIT_ACTIVE_RSP; done=1 from the following cycle; exactly 2 timeout-restart pulses; error_o=0.
- Unexpected traffic: 3 non-request codes, then a request.
  - Required: drop_cnt_o=3; response sent; with DROP_CNT_W=2 and 5 bad codes, drop_cnt_o=3 (saturated).
- Ack timeout: ACK_TIMEOUT=8; ack never asserted.
  - Required: error_o=1 after 8 cycles in SEND_RSP; TX_msg_valid_o=0; done=0.
- Abort mid-send: enable_i drops while TX_msg_valid_o=1, same cycle as an ack.
  - Required: next cycle IDLE with all outputs 0; re-enabling gives a clean exchange.
- Async reset mid-SEND_RSP: reset=0 between clock edges.
  - Required: all outputs 0 immediately; block resumes in IDLE after reset=1.
- Back-pressure hold: ack delayed 20 cycles with ACK_TIMEOUT=1000.
  - Required: TX_msg_o stable and TX_msg_valid_o continuously high for all 20 cycles.
